counter_mod_nb: RTL and testbench



---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_prescaler.sv | 43 ++++
 rtl/counter_mod_nb.sv | 82 ++++++++
 tb/tb_counter_mod_nb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants for the counter_mod_nb family: direction and mode
//   encodings plus the default widths that the UART baud generator also uses.
package counter_pkg;

  // Direction encoding on the dir input
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Terminal behaviour selected by the SATURATE parameter
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Default widths shared with the UART baud generator
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_PRE_WIDTH = 4;

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler
//   Enable prescaler for counter_mod_nb. It produces one step per
//   pre_div+1 enabled cycles.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset
//   ena      in   count enable
//   clr      in   synchronous clear of the prescaler count
//   load     in   synchronous load; also restarts the prescaler
//   pre_div  in   divide field; the step fires when pre_cnt reaches it
//   step     out  combinational enabled prescaler terminal
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRE_WIDTH = DEF_PRE_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 clr,
  input  logic                 load,
  input  logic [PRE_WIDTH-1:0] pre_div,
  output logic                 step
);

  logic [PRE_WIDTH-1:0] pre_cnt;

  // ">=" rather than "==" means a pre_div lowered below the current count
  // fires on the next enabled cycle instead of waiting for a full wrap.
  assign step = ena & (pre_cnt >= pre_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (clr || load) begin
      pre_cnt <= '0;
    end else if (ena) begin
      if (step) pre_cnt <= '0;
      else      pre_cnt <= pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_mod_nb.sv
// counter_mod_nb
//   Up/down counter with a programmable modulo, synchronous clear and load,
//   wrap or saturate terminal behaviour, a built-in enable prescaler and a
//   registered terminal-count strobe.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   ena       in   count enable (through the prescaler)
//   clr       in   synchronous clear (beats load)
//   load      in   synchronous load of load_val (beats step)
//   load_val  in   value loaded on load
//   dir       in   1 = up, 0 = down
//   mod_val   in   terminal value, range 0..mod_val
//   pre_div   in   steps once per pre_div+1 enabled cycles
//   count     out  registered count
//   step      out  combinational enabled prescaler terminal
//   tc        out  registered terminal-count pulse
module counter_mod_nb
  import counter_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               PRE_WIDTH = DEF_PRE_WIDTH,
  parameter int               SATURATE  = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 clr,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_val,
  input  logic                 dir,
  input  logic [WIDTH-1:0]     mod_val,
  input  logic [PRE_WIDTH-1:0] pre_div,
  output logic [WIDTH-1:0]     count,
  output logic                 step,
  output logic                 tc
);

  logic terminal;

  counter_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .clr     (clr),
    .load    (load),
    .pre_div (pre_div),
    .step    (step)
  );

  // Counting up, ">=" also catches a count left above mod_val by a load or
  // by lowering mod_val, so the counter recovers on the next step.
  assign terminal = (dir == DIR_UP) ? (count >= mod_val) : (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VAL;
      tc    <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tc    <= 1'b0;
    end else if (load) begin
      count <= load_val;
      tc    <= 1'b0;
    end else if (step) begin
      tc <= terminal;
      if (dir == DIR_UP) begin
        if (!terminal)                count <= count + 1'b1;
        else if (SATURATE == MODE_WRAP) count <= '0;
      end else begin
        if (!terminal)                count <= count - 1'b1;
        else if (SATURATE == MODE_WRAP) count <= mod_val;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_mod_nb.sv
// tb_counter_mod_nb
//   Drives a wrapping and a saturating counter_mod_nb with the same inputs.
//   A behavioural model predicts the next count/tc of each one, the
//   prediction is queued when the cycle is driven, and it is popped and
//   compared once the edge has happened.
module tb_counter_mod_nb;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena, clr, load, dir;
  logic [7:0] load_val, mod_val;
  logic [3:0] pre_div;
  logic [7:0] countA, countB;
  logic       stepA, stepB, tcA, tcB;

  typedef struct {
    logic [7:0] cnt;
    logic [3:0] pre;
    logic       tc;
  } mstate_t;

  typedef struct {
    mstate_t a;
    mstate_t b;
  } exp_t;

  mstate_t sa, sb;
  exp_t    scoreQ[$];
  int      compared = 0;
  int      mismatched = 0;
  int      pulsesA, pulsesB;

  always #5 clk = ~clk;

  counter_mod_nb #(.WIDTH(8), .PRE_WIDTH(4), .SATURATE(0), .RESET_VAL(8'd0)) dutA (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .mod_val(mod_val), .pre_div(pre_div),
    .count(countA), .step(stepA), .tc(tcA)
  );

  counter_mod_nb #(.WIDTH(8), .PRE_WIDTH(4), .SATURATE(1), .RESET_VAL(8'd0)) dutB (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .mod_val(mod_val), .pre_div(pre_div),
    .count(countB), .step(stepB), .tc(tcB)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Behavioural next-state for one counter given the current inputs.
  function automatic mstate_t modelNext(input mstate_t s, input bit sat);
    mstate_t n;
    bit      fire;
    bit      atEnd;
    fire  = ena && (s.pre >= pre_div);
    atEnd = dir ? (s.cnt >= mod_val) : (s.cnt == 8'd0);
    n = s;
    if (clr) begin
      n.cnt = 8'd0; n.pre = 4'd0; n.tc = 1'b0;
    end else if (load) begin
      n.cnt = load_val; n.pre = 4'd0; n.tc = 1'b0;
    end else begin
      if (ena) n.pre = fire ? 4'd0 : s.pre + 4'd1;
      n.tc = fire && atEnd;
      if (fire) begin
        if (dir && !atEnd)       n.cnt = s.cnt + 8'd1;
        else if (dir)            n.cnt = sat ? s.cnt : 8'd0;
        else if (!atEnd)         n.cnt = s.cnt - 8'd1;
        else                     n.cnt = sat ? 8'd0 : mod_val;
      end
    end
    return n;
  endfunction

  task automatic applyStimulus(input logic e, input logic c, input logic l,
                               input logic [7:0] lv, input logic d,
                               input logic [7:0] mv, input logic [3:0] pd);
    ena = e; clr = c; load = l; load_val = lv; dir = d; mod_val = mv; pre_div = pd;
  endtask

  // One clock: check step, queue the prediction, cross the edge, compare.
  task automatic tick();
    exp_t e;
    exp_t got;
    #1;
    checkOutput("stepA", stepA, int'(ena && (sa.pre >= pre_div)));
    checkOutput("stepB", stepB, int'(ena && (sb.pre >= pre_div)));
    e.a = modelNext(sa, 1'b0);
    e.b = modelNext(sb, 1'b1);
    scoreQ.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (scoreQ.size() == 0) begin
      checkOutput("queueEmpty", 1, 0);
    end else begin
      got = scoreQ.pop_front();
      checkOutput("countA", countA, got.a.cnt);
      checkOutput("tcA",    tcA,    got.a.tc);
      checkOutput("countB", countB, got.b.cnt);
      checkOutput("tcB",    tcB,    got.b.tc);
      sa = got.a;
      sb = got.b;
    end
  endtask

  task automatic resetModel();
    sa = '{cnt: 8'd0, pre: 4'd0, tc: 1'b0};
    sb = sa;
    scoreQ.delete();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd255, 4'd0);
    resetModel();
    @(negedge clk);
    checkOutput("rstCountA", countA, 0);
    checkOutput("rstTcA", tcA, 0);
    checkOutput("rstCountB", countB, 0);
    @(negedge clk);
    rst = 1'b0;

    // Free-run up through the 255 -> 0 wrap
    $display("[TB] free-run wrap");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd255, 4'd0);
    for (int i = 0; i < 260; i++) tick();
    checkOutput("wrapCountA", countA, 4);
    checkOutput("satCountB", countB, 255);

    // Prescaled modulo-10 count
    $display("[TB] prescaled modulo 10");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd9, 4'd3);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd9, 4'd3);
    pulsesA = 0;
    pulsesB = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (tcA) pulsesA++;
      if (tcB) pulsesB++;
    end
    checkOutput("pulsesA", pulsesA, 2);
    checkOutput("pulsesB", pulsesB, 13);

    // Saturating count down from a loaded 3, then drop enable
    $display("[TB] saturate down");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 1'b0, 8'd9, 4'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 1'b0, 8'd9, 4'd0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("satHoldTcB", tcB, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 8'd9, 4'd0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("satIdleCountB", countB, 0);
    checkOutput("satIdleTcB", tcB, 0);

    // Load above mod_val, then clr and load together
    $display("[TB] load above modulo");
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd200, 1'b1, 8'd9, 4'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd200, 1'b1, 8'd9, 4'd0);
    tick();
    checkOutput("overLoadCountA", countA, 0);
    checkOutput("overLoadTcA", tcA, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd77, 1'b1, 8'd9, 4'd0);
    tick();
    checkOutput("clrLoadCountA", countA, 0);
    checkOutput("clrLoadTcA", tcA, 0);

    // Asynchronous reset between edges
    $display("[TB] async reset mid-count");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd9, 4'd0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("preRstCountA", countA, 5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstCountA", countA, 0);
    checkOutput("asyncRstTcA", tcA, 0);
    checkOutput("asyncRstCountB", countB, 0);
    resetModel();
    @(negedge clk);
    rst = 1'b0;

    // Down with mod_val = 0
    $display("[TB] down with zero modulo");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 4'd0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("zeroModCountA", countA, 0);
    checkOutput("zeroModTcA", tcA, 1);

    // Random mix of every control
    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
                    1'($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 15)),
                    4'($urandom_range(0, 3)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
